// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU datapath self-test: ALU opcodes, the default
// datapath width, the self-test FSM state type and the constant vector
// tables (ALU vectors and PC script) that the self-test walks through.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int WIDTH_DEF = 16;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_SHR  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALU,
      ST_PC,
      ST_CORE,
      ST_CHECK,
      ST_FINISH
   } state_t;

   // Final values expected after the accumulation loop (sum of 0..15, 16 incs)
   localparam logic [15:0] CORE_ACC_EXP = 16'h0078;
   localparam logic [15:0] CORE_PC_EXP  = 16'h0010;

   typedef struct packed {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp;
   } alu_vec_t;

   typedef struct packed {
      logic        clear;
      logic        load;
      logic        inc;
      logic [15:0] val;
   } pc_ctl_t;

   function automatic alu_vec_t alu_vec(input logic [2:0] idx);
      case (idx)
         3'd0:    return '{op: OP_ADD, a: 16'h1234, b: 16'h1111, exp: 16'h2345};
         3'd1:    return '{op: OP_SUB, a: 16'h0005, b: 16'h0007, exp: 16'hFFFE};
         3'd2:    return '{op: OP_AND, a: 16'hF0F0, b: 16'h3C3C, exp: 16'h3030};
         3'd3:    return '{op: OP_OR,  a: 16'hF0F0, b: 16'h0F00, exp: 16'hFFF0};
         3'd4:    return '{op: OP_XOR, a: 16'hAAAA, b: 16'hFFFF, exp: 16'h5555};
         3'd5:    return '{op: OP_SHL, a: 16'h8001, b: 16'h0000, exp: 16'h0002};
         3'd6:    return '{op: OP_SHR, a: 16'h8001, b: 16'h0000, exp: 16'h4000};
         default: return '{op: OP_ADD, a: 16'hFFFF, b: 16'h0001, exp: 16'h0000};
      endcase
   endfunction

   function automatic pc_ctl_t pc_step_ctl(input logic [2:0] idx);
      case (idx)
         3'd0:    return '{clear: 1'b1, load: 1'b0, inc: 1'b0, val: 16'h0000};
         3'd3:    return '{clear: 1'b0, load: 1'b0, inc: 1'b0, val: 16'h0000};
         3'd4:    return '{clear: 1'b0, load: 1'b1, inc: 1'b0, val: 16'hFFFE};
         3'd7:    return '{clear: 1'b0, load: 1'b1, inc: 1'b0, val: 16'h0010};
         default: return '{clear: 1'b0, load: 1'b0, inc: 1'b1, val: 16'h0000};
      endcase
   endfunction

   function automatic logic [15:0] pc_step_exp(input logic [2:0] idx);
      case (idx)
         3'd0:    return 16'h0000;
         3'd1:    return 16'h0001;
         3'd2:    return 16'h0002;
         3'd3:    return 16'h0002;
         3'd4:    return 16'hFFFE;
         3'd5:    return 16'hFFFF;
         3'd6:    return 16'h0000;
         default: return 16'h0010;
      endcase
   endfunction

endpackage

// File: rtl/cpu_selftest_if.sv
// ---------------------------------------------------------------------------
// cpu_selftest_if
// Status bundle of a self-test block, so several blocks can be OR/AND
// combined at the top level.
//   result_out : sticky failure flag (1 = at least one check mismatched)
//   done       : all phases finished, held until reset
// master = the self-test block driving the status, slave = an observer.
// ---------------------------------------------------------------------------
interface cpu_selftest_if;
   logic result_out;
   logic done;

   modport master (output result_out, output done);
   modport slave  (input  result_out, input  done);
endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational ALU, results modulo 2^WIDTH with no carry out.
//   i_a, i_b : operands
//   i_op     : operation (cpu_pkg OP_* encoding)
//   o_y      : result
// ---------------------------------------------------------------------------
module alu
   import cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [2:0]       i_op,
   output logic [WIDTH-1:0] o_y
);

   always_comb begin
      o_y = '0;
      case (i_op)
         OP_ADD:  o_y = i_a + i_b;
         OP_SUB:  o_y = i_a - i_b;
         OP_AND:  o_y = i_a & i_b;
         OP_OR:   o_y = i_a | i_b;
         OP_XOR:  o_y = i_a ^ i_b;
         OP_SHL:  o_y = {i_a[WIDTH-2:0], 1'b0};
         OP_SHR:  o_y = {1'b0, i_a[WIDTH-1:1]};
         default: o_y = i_b;
      endcase
   end

endmodule

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// WIDTH-bit wrapping program counter. Priority clear > load > inc > hold.
//   clk, rst_n : clock, synchronous active-low reset (clears the PC)
//   i_clear    : force PC to 0
//   i_load     : load i_load_val
//   i_inc      : increment by one (wraps)
//   o_pc       : current PC value
// ---------------------------------------------------------------------------
module program_counter
   import cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_pc
);

   logic [WIDTH-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= '0;
      end else if (i_clear) begin
         r_pc <= '0;
      end else if (i_load) begin
         r_pc <= i_load_val;
      end else if (i_inc) begin
         r_pc <= r_pc + WIDTH'(1);
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/cpu_selftest.sv
// ---------------------------------------------------------------------------
// cpu_selftest
// Built-in self-test of the ALU and PC. Walks IDLE -> ALU -> PC -> CORE ->
// CHECK -> FINISH once after reset and reports through a status bundle.
//   WIDTH        : datapath width
//   INJECT_FAULT : invert bit 0 of the ALU result seen by the checker
//   clk, rst_n   : clock, synchronous active-low reset
//   o_stat       : status (result_out sticky fail, done)
// ---------------------------------------------------------------------------
module cpu_selftest
   import cpu_pkg::*;
#(
   parameter int WIDTH        = WIDTH_DEF,
   parameter bit INJECT_FAULT = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   cpu_selftest_if.master o_stat
);

   localparam logic [4:0] ALU_LAST  = 5'd7;
   localparam logic [4:0] PC_LAST   = 5'd8;   // one extra cycle to check step 7
   localparam logic [4:0] CORE_LAST = 5'd15;

   state_t           r_state;
   logic [4:0]       r_idx;
   logic [WIDTH-1:0] r_acc;
   logic             r_fail;
   logic             r_done;

   alu_vec_t         w_vec;
   pc_ctl_t          w_ctl;
   logic [2:0]       w_prev_idx;
   logic [WIDTH-1:0] w_prev_exp;
   logic [WIDTH-1:0] w_alu_a;
   logic [WIDTH-1:0] w_alu_b;
   logic [2:0]       w_alu_op;
   logic [WIDTH-1:0] w_alu_y;
   logic [WIDTH-1:0] w_alu_chk;
   logic [WIDTH-1:0] w_pc;
   logic             w_pc_clear;
   logic             w_pc_load;
   logic             w_pc_inc;

   assign w_vec      = alu_vec(r_idx[2:0]);
   assign w_ctl      = pc_step_ctl(r_idx[2:0]);
   // A PC step's effect is only visible one cycle later, so the check uses
   // the previous step's expectation (index 8 wraps to step 7).
   assign w_prev_idx = r_idx[2:0] - 3'd1;
   assign w_prev_exp = WIDTH'(pc_step_exp(w_prev_idx));
   assign w_alu_chk  = w_alu_y ^ WIDTH'(INJECT_FAULT);

   always_comb begin
      w_alu_a  = r_acc;
      w_alu_b  = w_pc;
      w_alu_op = OP_ADD;
      if (r_state == ST_ALU) begin
         w_alu_a  = WIDTH'(w_vec.a);
         w_alu_b  = WIDTH'(w_vec.b);
         w_alu_op = w_vec.op;
      end
   end

   always_comb begin
      w_pc_clear = 1'b0;
      w_pc_load  = 1'b0;
      w_pc_inc   = 1'b0;
      case (r_state)
         ST_PC: begin
            if (r_idx == PC_LAST) begin
               // Clearing here lets CORE start accumulating on its first edge
               w_pc_clear = 1'b1;
            end else begin
               w_pc_clear = w_ctl.clear;
               w_pc_load  = w_ctl.load;
               w_pc_inc   = w_ctl.inc;
            end
         end
         ST_CORE: w_pc_inc = 1'b1;
         default: ;
      endcase
   end

   alu #(.WIDTH(WIDTH)) u_alu (
      .i_a  (w_alu_a),
      .i_b  (w_alu_b),
      .i_op (w_alu_op),
      .o_y  (w_alu_y)
   );

   program_counter #(.WIDTH(WIDTH)) u_pc (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (w_pc_clear),
      .i_load     (w_pc_load),
      .i_load_val (WIDTH'(w_ctl.val)),
      .i_inc      (w_pc_inc),
      .o_pc       (w_pc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_acc   <= '0;
         r_fail  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_idx   <= '0;
               r_state <= ST_ALU;
            end
            ST_ALU: begin
               if (w_alu_chk != WIDTH'(w_vec.exp)) r_fail <= 1'b1;
               if (r_idx == ALU_LAST) begin
                  r_idx   <= '0;
                  r_state <= ST_PC;
               end else begin
                  r_idx <= r_idx + 5'd1;
               end
            end
            ST_PC: begin
               if (r_idx != 5'd0 && w_pc != w_prev_exp) r_fail <= 1'b1;
               if (r_idx == PC_LAST) begin
                  r_idx   <= '0;
                  r_acc   <= '0;
                  r_state <= ST_CORE;
               end else begin
                  r_idx <= r_idx + 5'd1;
               end
            end
            ST_CORE: begin
               r_acc <= w_alu_y;
               if (r_idx == CORE_LAST) begin
                  r_idx   <= '0;
                  r_state <= ST_CHECK;
               end else begin
                  r_idx <= r_idx + 5'd1;
               end
            end
            ST_CHECK: begin
               if (r_acc != WIDTH'(CORE_ACC_EXP) || w_pc != WIDTH'(CORE_PC_EXP))
                  r_fail <= 1'b1;
               r_state <= ST_FINISH;
            end
            ST_FINISH: r_done <= 1'b1;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_stat.result_out = r_fail;
   assign o_stat.done       = r_done;

endmodule

// File: tb/tb_cpu_selftest.sv
// ---------------------------------------------------------------------------
// tb_cpu_selftest
// Bench for cpu_selftest: a clean instance and a fault-injected instance run
// side by side under randomized reset/run schedules; a standalone ALU takes
// random operands. Expected values come from an edge-count model of the
// schedule and arithmetic models of the ALU and PC script.
// ---------------------------------------------------------------------------
module tb_cpu_selftest;
   import cpu_pkg::*;

   localparam int W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cpu_selftest_if u_if();
   cpu_selftest_if u_if_flt();

   cpu_selftest #(.WIDTH(W), .INJECT_FAULT(1'b0)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .o_stat (u_if)
   );

   cpu_selftest #(.WIDTH(W), .INJECT_FAULT(1'b1)) dut_flt (
      .clk    (clk),
      .rst_n  (rst_n),
      .o_stat (u_if_flt)
   );

   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic [2:0]   r_op;
   logic [W-1:0] w_y;

   alu #(.WIDTH(W)) u_alu (
      .i_a  (r_a),
      .i_b  (r_b),
      .i_op (r_op),
      .o_y  (w_y)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int k        = 0;   // edges sampling rst_n=1 since the last reset
   int pc_model [8];
   int acc_model;
   int pc_final;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h required %0h (k=%0d)", tag, got, exp, k);
      end
   endtask

   function automatic int alu_model(input int a, input int b, input int op);
      int r;
      case (op)
         0:       r = a + b;
         1:       r = a - b + 65536;
         2:       r = a & b;
         3:       r = a | b;
         4:       r = a ^ b;
         5:       r = a * 2;
         6:       r = a / 2;
         default: r = b;
      endcase
      return r % 65536;
   endfunction

   task automatic cycle(input logic rn);
      rst_n = rn;
      @(posedge clk);
      if (rn) k++; else k = 0;
      @(negedge clk);
      check("done",       {31'b0, u_if.done},           {31'b0, k >= 36});
      check("result",     {31'b0, u_if.result_out},     32'd0);
      check("flt_done",   {31'b0, u_if_flt.done},       {31'b0, k >= 36});
      check("flt_result", {31'b0, u_if_flt.result_out}, {31'b0, k >= 2});
      if (k == 0) begin
         check("rst_pc",  32'(dut.w_pc),  32'd0);
         check("rst_acc", 32'(dut.r_acc), 32'd0);
      end
      if (k >= 10 && k <= 17)
         check($sformatf("pc_step%0d", k - 10), 32'(dut.w_pc), 32'(pc_model[k - 10]));
      if (k == 34) begin
         check("core_acc", 32'(dut.r_acc), 32'(acc_model));
         check("core_pc",  32'(dut.w_pc),  32'(pc_final));
      end
   endtask

   task automatic run(input int round, input int n_rst, input int n_run);
      repeat (n_rst) cycle(1'b0);
      repeat (n_run) cycle(1'b1);
      $display("round %0d: reset %0d run %0d k=%0d done=%b result=%b flt_result=%b",
               round, n_rst, n_run, k, u_if.done, u_if.result_out, u_if_flt.result_out);
   endtask

   initial begin
      int pcv;
      int exp_y;

      // PC script model: clear, inc, inc, hold, load FFFE, inc, inc, load 0010
      pcv = 0;           pc_model[0] = pcv;
      pcv = (pcv + 1) % 65536; pc_model[1] = pcv;
      pcv = (pcv + 1) % 65536; pc_model[2] = pcv;
      pc_model[3] = pcv;
      pcv = 'hFFFE;      pc_model[4] = pcv;
      pcv = (pcv + 1) % 65536; pc_model[5] = pcv;
      pcv = (pcv + 1) % 65536; pc_model[6] = pcv;
      pcv = 'h0010;      pc_model[7] = pcv;

      acc_model = 0;
      pc_final  = 0;
      for (int i = 0; i < 16; i++) begin
         acc_model = (acc_model + pc_final) % 65536;
         pc_final  = (pc_final + 1) % 65536;
      end

      // Standalone ALU with random operands, edge values mixed in
      for (int i = 0; i < 48; i++) begin
         r_a  = (i % 6 == 0) ? 16'hFFFF : W'($urandom);
         r_b  = (i % 7 == 0) ? 16'h0001 : W'($urandom);
         r_op = 3'(i % 8);
         #1;
         exp_y = alu_model(int'(r_a), int'(r_b), int'(r_op));
         $display("alu op=%0d a=%h b=%h y=%h", r_op, r_a, r_b, w_y);
         check("alu", 32'(w_y), 32'(exp_y));
      end

      // Normal start, mid-run reset, then full run held in FINISH
      run(0, 2, 20);
      run(1, 1, 36 + 100);
      for (int r = 2; r < 8; r++)
         run(r, int'($urandom_range(1, 3)), int'($urandom_range(1, 50)));
      run(8, 1, 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
